// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider wrapper: divide control
// encodings, FSM state encoding and small decode helpers.
package div_seq_pkg;

  // Divide control encodings (ctrl[2] marks a divide-class op)
  localparam logic [2:0] CTRL_DIV  = 3'b100;
  localparam logic [2:0] CTRL_DIVU = 3'b101;
  localparam logic [2:0] CTRL_REM  = 3'b110;
  localparam logic [2:0] CTRL_REMU = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ctrl[0]==0 selects the signed flavour (DIV/REM)
  function automatic logic ctrl_is_signed(input logic [2:0] c);
    return ~c[0];
  endfunction

  // ctrl[1]==1 selects the remainder flavour (REM/REMU)
  function automatic logic ctrl_is_rem(input logic [2:0] c);
    return c[1];
  endfunction

endpackage

// File: rtl/div_seq_div.sv
// Combinational divider. Fully defined for every input, including divide
// by zero and signed overflow, so the sequencer can capture it blindly.
module div
  import div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_CTRL   = 3
) (
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  input  logic [DIV_CTRL-1:0]   i_ctrl,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam logic [DATA_WIDTH-1:0] W_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]            w_code;
  logic [DATA_WIDTH-1:0] w_quot_s;
  logic [DATA_WIDTH-1:0] w_rem_s;
  logic [DATA_WIDTH-1:0] w_quot_u;
  logic [DATA_WIDTH-1:0] w_rem_u;

  assign w_code = i_ctrl[2:0];

  // Raw quotient/remainder for both signednesses; guarded below
  always_comb begin
    w_quot_s = '0;
    w_rem_s  = '0;
    w_quot_u = '0;
    w_rem_u  = '0;
    if (i_divisor != '0) begin
      w_quot_u = i_dividend / i_divisor;
      w_rem_u  = i_dividend % i_divisor;
      if (!(i_dividend == W_MIN && i_divisor == '1)) begin
        w_quot_s = $unsigned($signed(i_dividend) / $signed(i_divisor));
        w_rem_s  = $unsigned($signed(i_dividend) % $signed(i_divisor));
      end
    end
  end

  // Select result by op, applying divide-by-zero and overflow rules
  always_comb begin
    o_result = '0;
    if (!w_code[2]) begin
      o_result = '0;
    end else if (i_divisor == '0) begin
      o_result = ctrl_is_rem(w_code) ? i_dividend : '1;
    end else if (ctrl_is_signed(w_code) && i_dividend == W_MIN && i_divisor == '1) begin
      o_result = ctrl_is_rem(w_code) ? '0 : i_dividend;
    end else begin
      case ({ctrl_is_rem(w_code), ctrl_is_signed(w_code)})
        2'b01:   o_result = w_quot_s;
        2'b00:   o_result = w_quot_u;
        2'b11:   o_result = w_rem_s;
        default: o_result = w_rem_u;
      endcase
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multicycle divide sequencer for the EX stage. Operands are registered
// and held for DIV_CYCLES cycles while the combinational divider settles;
// special cases bypass the wait and complete the cycle after accept.
//
// Handshakes: an op transfers on a rising edge where in_valid & in_ready
// & ~flush; a result transfers on a rising edge where out_valid &
// out_ready & ~flush. Neither valid depends combinationally on the
// matching ready, and result/rd_out are stable while out_valid is high.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_CTRL   = 3,
  parameter int DIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [DIV_CTRL-1:0]   ctrl,
  input  logic [4:0]            rd_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out,
  output logic                  stall,
  output state_t                dbg_state
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] W_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [DIV_CTRL-1:0]   r_ctrl;
  logic [4:0]            r_rd;
  logic [DATA_WIDTH-1:0] r_result;
  logic [4:0]            r_rd_out;

  logic                  w_accept;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic                  w_special;
  logic [DATA_WIDTH-1:0] w_special_res;
  logic [DATA_WIDTH-1:0] w_div_result;

  // Divider sees only the held operand registers
  div #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIV_CTRL  (DIV_CTRL)
  ) u_div (
    .i_dividend(r_op1),
    .i_divisor (r_op2),
    .i_ctrl    (r_ctrl),
    .o_result  (w_div_result)
  );

  // Special-case detection on the incoming op (short-circuit path)
  always_comb begin
    w_div_zero    = (op2 == '0);
    w_ovf         = ctrl_is_signed(ctrl[2:0]) && (op1 == W_MIN) && (op2 == '1);
    w_special     = ~ctrl[2] | w_div_zero | w_ovf;
    w_special_res = '0;
    if (!ctrl[2]) begin
      w_special_res = '0;
    end else if (w_div_zero) begin
      w_special_res = ctrl_is_rem(ctrl[2:0]) ? op1 : '1;
    end else if (w_ovf) begin
      w_special_res = ctrl_is_rem(ctrl[2:0]) ? '0 : op1;
    end
  end

  // Status outputs decoded from state alone
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    stall     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        stall    = 1'b0;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept  = in_valid & in_ready & ~flush;
  assign result    = r_result;
  assign rd_out    = r_rd_out;
  assign dbg_state = r_state;

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) w_state_nxt = w_special ? ST_DONE : ST_BUSY;
        ST_BUSY: if (r_cnt == '0) w_state_nxt = ST_DONE;
        ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, cycle counter and result/tag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_ctrl   <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op1  <= op1;
            r_op2  <= op2;
            r_ctrl <= ctrl;
            r_rd   <= rd_in;
            r_cnt  <= CNT_LOAD;
            if (w_special) begin
              r_result <= w_special_res;
              r_rd_out <= rd_in;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_result <= w_div_result;
            r_rd_out <= r_rd;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter DIV_CTRL, default 3, width of divide control code.
REQ-003 SHALL have parameter DIV_CYCLES, default 4, range 2..16, cycles operands are held stable for the multicycle divider path.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  EX stage presents a divide op.
REQ-007 SHALL have port in_ready  output  1  block accepts an op this cycle.
REQ-008 SHALL have ports op1, op2  input  DATA_WIDTH  dividend, divisor.
REQ-009 SHALL have port ctrl  input  DIV_CTRL  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 SHALL have port rd_in  input  5  destination register tag.
REQ-011 SHALL have port flush  input  1  pipeline flush; kills any op in flight.
REQ-012 SHALL have port out_valid  output  1  result available for EX/MEM.
REQ-013 SHALL have port out_ready  input  1  EX/MEM accepts result.
REQ-014 SHALL have ports result  output  DATA_WIDTH, rd_out  output  5  registered result and tag.
REQ-015 SHALL have port stall  output  1  hazard unit stall request; high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 in_ready SHALL equal (state==IDLE); accept = in_valid & in_ready & ~flush.
REQ-018 On accept SHALL latch op1, op2, ctrl, rd_in into operand registers and load cycle counter with DIV_CYCLES-1.
REQ-019 On accept with a special case (REQ-023/024) or ctrl[2]==0, SHALL go directly to DONE next cycle with the special result; else go to BUSY.
REQ-020 In BUSY counter SHALL decrement each cycle; operand registers SHALL stay constant; when counter==0, SHALL capture divider output into result and go to DONE.
REQ-021 Latency: normal op out_valid rises exactly DIV_CYCLES cycles after accept edge; special case exactly 1 cycle.
REQ-022 In DONE out_valid=1, result/rd_out held stable until out_ready; on out_valid & out_ready SHALL return to IDLE (next accept earliest one cycle later).
REQ-023 Divide-by-zero (op2==0): DIV/DIVU result SHALL be all ones; REM/REMU result SHALL be op1.
REQ-024 Signed overflow (op1==most-negative, op2==all ones, ctrl 100/110): DIV result SHALL be op1; REM result SHALL be 0.
REQ-025 ctrl[2]==0 SHALL be accepted and return result 0.
REQ-026 Normal results SHALL come from the divider sub-module fed only by the operand registers, never by live inputs.
REQ-027 flush in any state SHALL force IDLE next cycle, deassert out_valid, discard result; flush SHALL win over simultaneous in_valid and out_ready.
REQ-028 stall SHALL be combinational from state only.

Reset
REQ-029 On rst: state IDLE, counter 0, out_valid 0, result 0, rd_out 0, operand registers 0; in_ready 1 and stall 0 in the cycle after reset.
REQ-030 rst mid-BUSY or mid-DONE SHALL abandon the op with no out_valid pulse; rst SHALL take priority over flush and accept.

Structure
REQ-031 Divide ctrl encodings (DIV, DIVU, REM, REMU) and the FSM state enum SHALL be in the shared package.
REQ-032 SHALL instantiate exactly one sub-module: the existing combinational divider div, with DATA_WIDTH/DIV_CTRL passed through.
REQ-033 Counter width SHALL be $clog2(DIV_CYCLES); no other arithmetic in this block beyond special-case detection.

Verification
REQ-034 DIVU 100/7, out_ready=1 -> result 14, out_valid exactly 4 cycles after accept, stall high 4 cycles.
REQ-035 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
REQ-036 DIVU 5/0 -> 0xFFFFFFFF after 1 cycle; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-037 out_ready low 3 cycles in DONE -> result/rd_out stable, in_ready 0, new in_valid ignored; accept resumes cycle after handshake.
REQ-038 flush asserted in 2nd BUSY cycle -> no out_valid ever for that op, in_ready 1 next cycle; rst in BUSY same.
REQ-039 Back-to-back ops with in_valid held high -> each result correct, tags in order, one op per DIV_CYCLES+1 cycles minimum.
